// File: rtl/board_rst_ctrl_pkg.sv
// Shared encodings for the board reset/strap conditioner.
package board_rst_ctrl_pkg;

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_BTN  = 2'b01;
  localparam logic [1:0] CAUSE_SOFT = 2'b10;

  localparam logic [7:0] WARM_CNT_MAX = 8'hFF;

  // Saturating increment for the warm-reset counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == WARM_CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/board_rst_ctrl_if.sv
// Board-side pins and SoC-side reset/strap outputs of the reset conditioner.
interface board_rst_ctrl_if;
  logic       btn_rst_n_i;
  logic       dbg_pin_i;
  logic       soft_rst_req_i;
  logic       soc_rst_n_o;
  logic       dbg_pin_o;
  logic [1:0] rst_cause_o;
  logic [7:0] warm_rst_cnt_o;

  // Board / stimulus side.
  modport master (
    output btn_rst_n_i, dbg_pin_i, soft_rst_req_i,
    input  soc_rst_n_o, dbg_pin_o, rst_cause_o, warm_rst_cnt_o
  );

  // Reset conditioner side.
  modport slave (
    input  btn_rst_n_i, dbg_pin_i, soft_rst_req_i,
    output soc_rst_n_o, dbg_pin_o, rst_cause_o, warm_rst_cnt_o
  );
endinterface

// File: rtl/board_rst_ctrl_debounce.sv
// Two-flop synchroniser followed by a consecutive-sample debouncer.
// INVERT flips the synchronised level before debouncing so an active-low
// pin can be presented as an active-high debounced level.
module debounce #(
  parameter int   DB_CYCLES    = 50000,
  parameter int   DB_CNT_W     = 16,
  parameter logic SYNC_RST_VAL = 1'b0,
  parameter logic INVERT       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_CYCLES - 1);

  logic                sync_q1;
  logic                sync_q2;
  logic                level;
  logic [DB_CNT_W-1:0] cnt_q;

  // Bring the asynchronous pin into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= SYNC_RST_VAL;
      sync_q2 <= SYNC_RST_VAL;
    end else begin
      sync_q1 <= din;
      sync_q2 <= sync_q1;
    end
  end

  assign level = sync_q2 ^ INVERT;

  // Accept a new level only after it has persisted for DB_CYCLES samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout  <= 1'b0;
      cnt_q <= '0;
    end else if (level == dout) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      dout  <= level;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DB_CNT_W'(1);
    end
  end

endmodule

// File: rtl/board_rst_ctrl.sv
// Board reset and strap conditioner feeding the SoC reset and debug strap.
//
// state | meaning
// HOLD  | SoC held in reset; hold timer runs once the button is released
// RUN   | SoC released; button edge or soft request re-enters HOLD
module board_rst_ctrl
  import board_rst_ctrl_pkg::*;
#(
  parameter int DB_CYCLES   = 50000,
  parameter int DB_CNT_W    = 16,
  parameter int HOLD_CYCLES = 16,
  parameter int HOLD_CNT_W  = 5
) (
  input logic             clk,
  input logic             rst,
  board_rst_ctrl_if.slave bus
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_CYCLES - 1);

  logic                  btn_db;
  logic                  strap_db;
  logic                  btn_db_d;
  logic                  btn_rise_q;
  state_t                state_q;
  logic [HOLD_CNT_W-1:0] hold_cnt_q;
  logic                  soc_rst_n_q;
  logic [1:0]            cause_q;
  logic [7:0]            warm_cnt_q;

  debounce #(
    .DB_CYCLES    (DB_CYCLES),
    .DB_CNT_W     (DB_CNT_W),
    .SYNC_RST_VAL (1'b1),
    .INVERT       (1'b1)
  ) u_btn_db (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.btn_rst_n_i),
    .dout (btn_db)
  );

  debounce #(
    .DB_CYCLES    (DB_CYCLES),
    .DB_CNT_W     (DB_CNT_W),
    .SYNC_RST_VAL (1'b0),
    .INVERT       (1'b0)
  ) u_strap_db (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.dbg_pin_i),
    .dout (strap_db)
  );

  // Registered rising-edge pulse of the debounced button press.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_db_d   <= 1'b0;
      btn_rise_q <= 1'b0;
    end else begin
      btn_db_d   <= btn_db;
      btn_rise_q <= btn_db & ~btn_db_d;
    end
  end

  // Reset sequencing FSM with hold timer, cause register and warm-reset count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HOLD;
      hold_cnt_q  <= '0;
      soc_rst_n_q <= 1'b0;
      cause_q     <= CAUSE_POR;
      warm_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (bus.soft_rst_req_i) begin
            hold_cnt_q <= '0;
            cause_q    <= CAUSE_SOFT;
          end else if (btn_db) begin
            hold_cnt_q <= '0;
          end else if (hold_cnt_q == HOLD_LAST) begin
            state_q     <= ST_RUN;
            soc_rst_n_q <= 1'b1;
            hold_cnt_q  <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_CNT_W'(1);
          end
        end
        ST_RUN: begin
          // Button has priority when both requests land in the same cycle.
          if (btn_rise_q) begin
            state_q     <= ST_HOLD;
            soc_rst_n_q <= 1'b0;
            hold_cnt_q  <= '0;
            cause_q     <= CAUSE_BTN;
            warm_cnt_q  <= sat_inc8(warm_cnt_q);
          end else if (bus.soft_rst_req_i) begin
            state_q     <= ST_HOLD;
            soc_rst_n_q <= 1'b0;
            hold_cnt_q  <= '0;
            cause_q     <= CAUSE_SOFT;
            warm_cnt_q  <= sat_inc8(warm_cnt_q);
          end
        end
        default: begin
          state_q     <= ST_HOLD;
          soc_rst_n_q <= 1'b0;
          hold_cnt_q  <= '0;
        end
      endcase
    end
  end

  assign bus.soc_rst_n_o    = soc_rst_n_q;
  assign bus.dbg_pin_o      = strap_db;
  assign bus.rst_cause_o    = cause_q;
  assign bus.warm_rst_cnt_o = warm_cnt_q;

endmodule

// File: doc/board_rst_ctrl.md
# board_rst_ctrl

Board-level reset and strap conditioner that sits directly upstream of `tinyriscv_soc_top` and drives its `rst` and `uart_debug_pin` inputs. It synchronises and debounces the asynchronous reset push-button and the UART-download strap pin. It stretches every reset request into a clean, fixed-length, active-low SoC reset. It also records the cause of the last reset and keeps a count of warm resets.

## Interface

**Parameters**

- `DB_CYCLES`, default 50000: number of consecutive stable synchronised samples required before a debounced level changes.
- `DB_CNT_W`, default 16: width of the debounce counter. Must satisfy 2^`DB_CNT_W` > `DB_CYCLES`.
- `HOLD_CYCLES`, default 16: minimum number of cycles `soc_rst_n_o` stays low for any reset. Must be ≥ 1.
- `HOLD_CNT_W`, default 5: width of the hold counter. Must satisfy 2^`HOLD_CNT_W` > `HOLD_CYCLES`.

**Ports**

- `clk`, input, 1: system clock.
- `rst`, input, 1: power-on reset, synchronous, active-high.
- `btn_rst_n_i`, input, 1: reset push-button, asynchronous, active-low. Idles high.
- `dbg_pin_i`, input, 1: UART-download strap, asynchronous, active-high.
- `soft_rst_req_i`, input, 1: single-cycle software reset request, synchronous to `clk`.
- `soc_rst_n_o`, output, 1: reset to the SoC `rst` input, active-low. Registered.
- `dbg_pin_o`, output, 1: debounced strap level, driven to the SoC `uart_debug_pin`.
- `rst_cause_o`, output, 2: cause of the last reset. `2'b00` = power-on, `2'b01` = button, `2'b10` = soft; `2'b11` is unused.
- `warm_rst_cnt_o`, output, 8: number of button and soft resets since power-on. Saturates at 255.

## Operation

**Input conditioning**

- `btn_rst_n_i` and `dbg_pin_i` each pass through a 2-flop synchroniser.
- Each synchronised signal then feeds its own debounce instance.
- The button is inverted before debouncing, giving `btn_db` (1 = pressed).

**Debounce behaviour**

- The debounced output changes only after the synchronised input has differed from the current output for `DB_CYCLES` consecutive cycles.
- Any cycle in which the input equals the current output clears the counter.

**State machine**

The FSM has two states, HOLD and RUN.

- **`rst` = 1:** state = HOLD, hold counter = 0, `rst_cause_o` = 00, `warm_rst_cnt_o` = 0.
- **HOLD:** `soc_rst_n_o` = 0.
  - While `btn_db` = 1, the hold counter is held at 0.
  - Otherwise the hold counter increments each cycle.
  - When the counter reaches `HOLD_CYCLES`-1, the next edge moves to RUN.
  - A `soft_rst_req_i` pulse in HOLD clears the counter and sets cause = 10. It does not increment `warm_rst_cnt_o`.
- **RUN:** `soc_rst_n_o` = 1.
  - A rising edge of `btn_db` moves to HOLD, clears the counter, sets cause = 01 and increments `warm_rst_cnt_o`.
  - A `soft_rst_req_i` pulse does the same, but sets cause = 10.
  - If both occur in the same cycle, the button wins: cause = 01 and the count increments by exactly 1.

**Strap handling**

- `dbg_pin_o` is independent of the FSM and is only reset by `rst`.

## Timing

**Reset values**

While `rst` = 1, all outputs take these values:

- `soc_rst_n_o` = 0
- `dbg_pin_o` = 0
- `rst_cause_o` = 00
- `warm_rst_cnt_o` = 0
- Synchroniser flops: button = 1 (idle), strap = 0.
- Debounced levels and debounce counters = 0.

**Latencies**

- **Power-on release:** `soc_rst_n_o` rises on the `HOLD_CYCLES`-th rising edge after the first edge that samples `rst` = 0.
- **Button press to reset:** 2 (synchroniser) + `DB_CYCLES` (debounce) + 1 (edge detect) + 1 (FSM) cycles from the pin edge to `soc_rst_n_o` falling.
- **Button release to RUN:** `soc_rst_n_o` rises `HOLD_CYCLES` cycles after `btn_db` falls.
- **Soft request:** `soc_rst_n_o` falls on the edge after the pulse and stays low for exactly `HOLD_CYCLES` cycles.

**Boundary conditions**

- A glitch shorter than `DB_CYCLES` produces no output change.
- `rst` asserted mid-HOLD or mid-debounce aborts everything immediately.

## Structure

- The shared package holds the cause encodings `CAUSE_POR`, `CAUSE_BTN` and `CAUSE_SOFT`, and the FSM state encodings.
- One natural sub-module, `debounce`, is parameterised by `DB_CYCLES`, `DB_CNT_W` and the reset level. It contains the synchroniser and the counter, and is instantiated twice (button and strap).
- The top level contains the edge detector, the FSM, the hold counter, the cause register and the saturating counter.

## Test plan

All scenarios use `DB_CYCLES` = 4 and `HOLD_CYCLES` = 16.

- **Power-on release:** `rst` high for 5 cycles, then low → `soc_rst_n_o` = 0 until the 16th edge, then 1; cause = 00; count = 0.
- **Button glitch rejected:** after RUN, drive `btn_rst_n_i` low for 3 cycles → no change on `soc_rst_n_o`.
- **Button hold and release:** button low for 40 cycles → `soc_rst_n_o` falls 2+4+2 cycles after the press and rises 16 cycles after `btn_db` falls; cause = 01; count = 1.
- **Soft request:** one-cycle `soft_rst_req_i` in RUN → exactly 16 cycles low; cause = 10; count increments.
- **Simultaneous events and mid-HOLD retrigger:** button edge and soft request in the same cycle → cause = 01, count +1 only. A soft request 10 cycles into HOLD restarts the 16-cycle hold, cause = 10, count unchanged.
- **Count saturation and strap debounce:** 260 soft resets → count = 255. Toggle `dbg_pin_i` high → `dbg_pin_o` = 1 after 6 cycles; a mid-sequence `rst` returns every output to its reset value.
